secuenciador_izq_der: RTL and testbench
=======================================

SECUENCIADOR_IZQ_DER -- requirements
Module: secuenciador_izq_der

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the operand width in bits.
REQ-002 The block SHALL have parameter SLICE, default 2, meaning the bits compared per scan cycle; N SHALL be an integer multiple of SLICE.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1, requesting a comparison of wordA against wordB.
REQ-006 The block SHALL have ports wordA and wordB, input, N each, the operands, sampled only when start is accepted.
REQ-007 The block SHALL have port ack, input, 1, consumer acknowledge of the current result.
REQ-008 The block SHALL have port busy, output, 1, high in SCAN.
REQ-009 The block SHALL have port valid, output, 1, high in DONE.
REQ-010 The block SHALL have ports gt, eq, lt, output, 1 each, one-hot result of A versus B (unsigned), meaningful only while valid.

Function
REQ-011 The FSM SHALL have states IDLE, SCAN and DONE.
REQ-012 In IDLE, start=1 SHALL be accepted: wordA/wordB load into shift registers, the slice counter clears, and the state moves to SCAN.
REQ-013 start in SCAN SHALL be ignored; operands SHALL NOT be reloaded.
REQ-014 Each SCAN cycle SHALL compare the top SLICE bits of both registers (left to right, MSB first), then shift both left by SLICE and increment the counter.
REQ-015 The counter SHALL be ceil(log2(N/SLICE)) bits wide (minimum 1) and SHALL NOT wrap during a scan.
REQ-016 The first differing slice SHALL set the result (gt if A slice > B slice, else lt); later slices SHALL NOT change it.
REQ-017 If all N/SLICE slices are equal, the result SHALL be eq.
REQ-018 Timing: with cycle 0 the cycle start is accepted, SCAN SHALL occupy cycles 1..N/SLICE and valid SHALL be 1 from cycle N/SLICE+1 (default: cycle 5).
REQ-019 In DONE, result and valid SHALL hold until ack=1; then valid SHALL drop at the next edge.
REQ-020 In DONE, ack=1 with start=1 in the same cycle SHALL load the new operands and go directly to SCAN (back-to-back); start without ack SHALL be ignored.
REQ-021 ack outside DONE SHALL have no effect.

Reset
REQ-022 Asserting reset SHALL immediately force IDLE, busy=0, valid=0, gt=eq=lt=0, counter and shift registers to 0, including mid-scan.
REQ-023 After reset deassertion the block SHALL accept start on the first clock edge.

Configuration
REQ-024 Macro SECUENCIADOR_EARLY_EXIT_EN, when defined, SHALL end SCAN on the first differing slice: for first difference in slice i (0-based from MSB), valid SHALL be 1 from cycle i+2.
REQ-025 Without SECUENCIADOR_EARLY_EXIT_EN, latency SHALL always be per REQ-018 regardless of operands.

Structure
REQ-026 State encoding (IDLE=2'b00, SCAN=2'b01, DONE=2'b10) and result encodings SHALL live in shared package izq_der_pkg.
REQ-027 The per-slice compare SHALL be a combinational sub-module comparador_rebanada (SLICE-bit inputs; gt/lt outputs), instantiated once.

Verification
REQ-028 A=8'hA5, B=8'hA5, start in cycle 0 -> eq=1, valid=1 from cycle 5, both configurations.
REQ-029 A=8'h80, B=8'h7F -> gt=1; valid from cycle 2 with SECUENCIADOR_EARLY_EXIT_EN, cycle 5 without.
REQ-030 A=8'h12, B=8'h13 -> lt=1, valid from cycle 5 in both configurations (difference in last slice).
REQ-031 reset pulsed in cycle 2 of a scan -> busy=valid=gt=eq=lt=0 immediately; new start with A=8'h01, B=8'h00 -> gt=1 at cycle 5.
REQ-032 start re-pulsed with changed operands during SCAN -> original result unchanged; ack+start in DONE with A=8'h00, B=8'hFF -> valid drops, lt=1 valid again after 4 SCAN cycles.

Source files
------------

// File: rtl/izq_der_pkg.sv
// izq_der_pkg: shared FSM state and result encodings for the left-to-right sequential comparator
package izq_der_pkg;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_SCAN = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;
  function automatic int cnt_w(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction
endpackage

// File: rtl/comparador_rebanada.sv
// comparador_rebanada: unsigned magnitude compare of one SLICE-bit slice
module comparador_rebanada #(
  parameter int SLICE = 2
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  output logic             o_gt,
  output logic             o_lt
);
  assign o_gt = i_a > i_b;
  assign o_lt = i_a < i_b;
endmodule

// File: rtl/secuenciador_izq_der.sv
// secuenciador_izq_der: MSB-first sliced compare of wordA vs wordB (gt/eq/lt) with ack handshake
// Optional SECUENCIADOR_EARLY_EXIT_EN: finish the scan at the first differing slice.
module secuenciador_izq_der
  import izq_der_pkg::*;
#(
  parameter int N     = 8,
  parameter int SLICE = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] wordA,
  input  logic [N-1:0] wordB,
  input  logic         ack,
  output logic         busy,
  output logic         valid,
  output logic         gt,
  output logic         eq,
  output logic         lt
);
  localparam int K  = N / SLICE;
  localparam int CW = cnt_w(K);
  logic [1:0]    r_state;
  logic [N-1:0]  r_a, r_b;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_res;
  logic          w_gt, w_lt, w_last, w_load, w_end;
  logic [2:0]    w_res_nxt;
  comparador_rebanada #(.SLICE(SLICE)) u_cmp (
    .i_a  (r_a[N-1 -: SLICE]),
    .i_b  (r_b[N-1 -: SLICE]),
    .o_gt (w_gt),
    .o_lt (w_lt)
  );
  assign w_load = start && (r_state == ST_IDLE || (r_state == ST_DONE && ack));
  assign w_last = r_cnt == CW'(K - 1);
`ifdef SECUENCIADOR_EARLY_EXIT_EN
  assign w_end = w_last || w_gt || w_lt;
`else
  assign w_end = w_last;
`endif
  // first differing slice wins; eq only once the last slice also matched
  assign w_res_nxt = (r_res != RES_NONE) ? r_res :
                     w_gt ? RES_GT : w_lt ? RES_LT : w_last ? RES_EQ : RES_NONE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_res   <= RES_NONE;
    end else if (w_load) begin
      r_state <= ST_SCAN;
      r_a     <= wordA;
      r_b     <= wordB;
      r_cnt   <= '0;
      r_res   <= RES_NONE;
    end else if (r_state == ST_SCAN) begin
      r_a     <= r_a << SLICE;
      r_b     <= r_b << SLICE;
      r_cnt   <= w_last ? r_cnt : r_cnt + 1'b1;
      r_res   <= w_res_nxt;
      r_state <= w_end ? ST_DONE : ST_SCAN;
    end else if (r_state == ST_DONE && ack) begin
      r_state <= ST_IDLE;
    end
  end
  assign busy  = r_state == ST_SCAN;
  assign valid = r_state == ST_DONE;
  assign gt    = valid && r_res == RES_GT;
  assign eq    = valid && r_res == RES_EQ;
  assign lt    = valid && r_res == RES_LT;
endmodule

// File: tb/tb_secuenciador_izq_der.sv
// tb_secuenciador_izq_der: randomized self-checking bench against a latency/result reference model
module tb_secuenciador_izq_der;
  localparam int N = 8;
  localparam int SLICE = 2;
  localparam int K = N / SLICE;
  logic clk, reset, start, ack;
  logic [N-1:0] wordA, wordB;
  logic busy, valid, gt, eq, lt;
  int n_cmp = 0;
  int n_bad = 0;
  secuenciador_izq_der #(.N(N), .SLICE(SLICE)) dut (
    .clk(clk), .reset(reset), .start(start), .wordA(wordA), .wordB(wordB),
    .ack(ack), .busy(busy), .valid(valid), .gt(gt), .eq(eq), .lt(lt)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [2:0] exp_res(input logic [N-1:0] a, input logic [N-1:0] b);
    return (a > b) ? 3'b100 : (a < b) ? 3'b001 : 3'b010;
  endfunction
  // cycle (relative to start acceptance in cycle 0) in which valid first rises
  function automatic int exp_lat(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef SECUENCIADOR_EARLY_EXIT_EN
    for (int i = 0; i < K; i++)
      if (((a >> (N - SLICE * (i + 1))) % (1 << SLICE)) != ((b >> (N - SLICE * (i + 1))) % (1 << SLICE)))
        return i + 2;
`endif
    return K + 1;
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic run_txn(input logic [N-1:0] a, input logic [N-1:0] b, input bit with_ack);
    int lat;
    int c;
    logic [2:0] r;
    lat = exp_lat(a, b);
    r = exp_res(a, b);
    wordA = a; wordB = b; start = 1; ack = with_ack;
    step();
    start = 0; ack = 0; c = 1;
    while (c < lat) begin
      chk("busy_scan", 32'(busy), 1);
      chk("valid_scan", 32'(valid), 0);
      start = 1'($urandom_range(0, 1));
      ack = 1'($urandom_range(0, 1));
      wordA = N'($urandom); wordB = N'($urandom);
      step();
      c++;
    end
    start = 0; ack = 0;
    chk("valid_done", 32'(valid), 1);
    chk("busy_done", 32'(busy), 0);
    chk("result", 32'({gt, eq, lt}), 32'(r));
    repeat ($urandom_range(0, 2)) begin
      start = 1; wordA = N'($urandom); wordB = N'($urandom);
      step();
      start = 0;
      chk("hold_valid", 32'(valid), 1);
      chk("hold_result", 32'({gt, eq, lt}), 32'(r));
    end
  endtask
  task automatic release_result;
    ack = 1;
    step();
    ack = 0;
    chk("ack_valid", 32'(valid), 0);
    chk("ack_busy", 32'(busy), 0);
    chk("ack_flags", 32'({gt, eq, lt}), 0);
  endtask
  initial begin
    reset = 1; start = 0; ack = 0; wordA = '0; wordB = '0;
    repeat (2) step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_flags", 32'({gt, eq, lt}), 0);
    reset = 0;
    run_txn(8'hA5, 8'hA5, 0); release_result();
    run_txn(8'h80, 8'h7F, 0); release_result();
    run_txn(8'h12, 8'h13, 0); release_result();
    ack = 1; step(); ack = 0;
    chk("idle_ack_valid", 32'(valid), 0);
    chk("idle_ack_busy", 32'(busy), 0);
    wordA = 8'hFF; wordB = 8'h00; start = 1;
    step();
    start = 0;
    step();
    reset = 1;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_valid", 32'(valid), 0);
    chk("async_rst_flags", 32'({gt, eq, lt}), 0);
    #2 reset = 0;
    run_txn(8'h01, 8'h00, 0);
    run_txn(8'h00, 8'hFF, 1);
    release_result();
    for (int t = 0; t < 60; t++) begin
      logic [N-1:0] a, b;
      a = N'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a ^ N'(1 << $urandom_range(0, N - 1)) : N'($urandom);
      if ($urandom_range(0, 4) == 0) b = a;
      run_txn(a, b, 0);
      if ($urandom_range(0, 1) == 1) release_result();
      else run_txn(b, a, 1);
      if (valid) release_result();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
